// File: rtl/usb_tx_serializer.sv
// ---------------------------------------------------------------------------
// usb_tx_serializer : byte stream to USB D+/D- (SYNC, stuffing, NRZI, EOP)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module usb_tx_serializer #(
  parameter int         CLKS_PER_BIT = 8,
  parameter logic [7:0] SYNC_BYTE    = 8'h80
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       d_plus,
  output logic       d_minus,
  output logic       tx_busy,
  output logic       tx_err
);

  localparam int            TW        = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP_SE0, EOP_J} state_t;

  state_t        state;
  logic [TW-1:0] tick;
  logic [2:0]    bit_cnt;
  logic [2:0]    ones_cnt;
  logic [7:0]    shreg;
  logic          last_q;
  logic          stuff;
  logic          level;

  logic          period_end;
  logic          cur_bit;
  logic [2:0]    ones_next;
  logic [2:0]    nxt_idx;
  logic          advance;
  logic          byte_end;
  logic          start_bit;
  logic          new_bit;
  logic          new_level;

  always_comb begin
    period_end = (state != IDLE) && (tick == TICK_LAST);
    cur_bit    = stuff ? 1'b0 : ((state == SYNC) ? SYNC_BYTE[bit_cnt] : shreg[bit_cnt]);
    ones_next  = cur_bit ? ones_cnt + 3'd1 : 3'd0;
    // A sixth consecutive one forces a stuffed 0 before anything else moves on.
    advance    = stuff || (ones_next != 3'd6);
    byte_end   = period_end && advance && (bit_cnt == 3'd7);
    nxt_idx    = bit_cnt + 3'd1;

    start_bit = 1'b0;
    new_bit   = 1'b0;
    case (state)
      IDLE: begin
        if (tx_valid) begin
          start_bit = 1'b1;
          new_bit   = SYNC_BYTE[0];
        end
      end
      SYNC, DATA: begin
        if (period_end) begin
          if (!advance) begin
            start_bit = 1'b1;
          end else if (bit_cnt != 3'd7) begin
            start_bit = 1'b1;
            new_bit   = (state == SYNC) ? SYNC_BYTE[nxt_idx] : shreg[nxt_idx];
          end else if (state == SYNC) begin
            start_bit = 1'b1;
            new_bit   = shreg[0];
          end else if (!last_q && tx_valid) begin
            start_bit = 1'b1;
            new_bit   = tx_data[0];
          end
        end
      end
      default: ;
    endcase
    new_level = new_bit ? level : ~level;
  end

  assign tx_ready = (state == IDLE) || ((state == DATA) && byte_end && !last_q);
  assign tx_err   = (state == DATA) && byte_end && !last_q && !tx_valid;
  assign tx_busy  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state    <= IDLE;
      tick     <= '0;
      bit_cnt  <= 3'd0;
      ones_cnt <= 3'd0;
      stuff    <= 1'b0;
      shreg    <= 8'd0;
      last_q   <= 1'b0;
      level    <= 1'b1;
      d_plus   <= 1'b1;
      d_minus  <= 1'b0;
    end else begin
      if (state != IDLE) tick <= period_end ? '0 : tick + TW'(1);

      case (state)
        IDLE: begin
          if (tx_valid) begin
            shreg    <= tx_data;
            last_q   <= tx_last;
            state    <= SYNC;
            tick     <= '0;
            bit_cnt  <= 3'd0;
            ones_cnt <= 3'd0;
            stuff    <= 1'b0;
          end
        end
        SYNC, DATA: begin
          if (period_end) begin
            ones_cnt <= advance ? ones_next : 3'd0;
            stuff    <= !advance;
            if (advance) begin
              bit_cnt <= nxt_idx;
              if (bit_cnt == 3'd7) begin
                if (state == SYNC) begin
                  state <= DATA;
                end else if (last_q || !tx_valid) begin
                  state <= EOP_SE0;
                end else begin
                  shreg  <= tx_data;
                  last_q <= tx_last;
                end
              end
            end
          end
        end
        EOP_SE0: begin
          if (period_end) begin
            bit_cnt <= nxt_idx;
            if (bit_cnt == 3'd1) begin
              state   <= EOP_J;
              bit_cnt <= 3'd0;
            end
          end
        end
        EOP_J: begin
          if (period_end) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (start_bit) begin
        level   <= new_level;
        d_plus  <= new_level;
        d_minus <= ~new_level;
      end else if ((state == DATA) && byte_end) begin
        d_plus  <= 1'b0;
        d_minus <= 1'b0;
      end else if ((state == EOP_SE0) && period_end && (bit_cnt == 3'd1)) begin
        level   <= 1'b1;
        d_plus  <= 1'b1;
        d_minus <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
